// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: shift-unit op codes and FSM states.
package shift_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_CLR  = 3'd0,
    OP_LOAD = 3'd1,
    OP_LSR  = 3'd2,
    OP_LSL  = 3'd3,
    OP_ASR  = 3'd4,
    OP_SIN  = 3'd5,
    OP_ROR  = 3'd6,
    OP_ROL  = 3'd7
  } shop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  // Ops that only need the load pulse and never enter RUN.
  function automatic logic is_load_only(input shop_e op);
    return (op == OP_CLR) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/shift_sequencer_tick_gen.sv
// Free-running TICK_DIV divider with synchronous clear; tick_o is high on the
// last count of each period while enabled.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Divider counter: cleared on reset or clear, wraps at TERM while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for the 8-bit shift unit: accepts one command,
// issues a load pulse, then paced shift pulses, then a done pulse.
// Build option SHIFT_SEQ_SINGLE_STEP_EN: adds the step port; RUN pulses are
// paced by step instead of the TICK_DIV divider.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              abort,
`ifdef SHIFT_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              sh_en,
  output logic [OP_W-1:0]   sh_ctrl,
  output logic [DATA_W-1:0] sh_din,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  steps_left
);

  seq_state_e        state_q, state_d;
  shop_e             op_q, op_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sh_en_q, sh_en_d;
  shop_e             sh_ctrl_q, sh_ctrl_d;
  logic [DATA_W-1:0] sh_din_q, sh_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  steps_q, steps_d;

  logic run_fire;   // shift pulse request while in RUN
  logic load_fire;  // first shift pulse decided already in LOAD (TICK_DIV==1)

`ifdef SHIFT_SEQ_SINGLE_STEP_EN
  assign run_fire  = step;
  assign load_fire = 1'b0;
`else
  logic tick;
  logic tick_en;

  // Divider runs from the LOAD cycle so the first shift lands TICK_DIV cycles
  // after the load pulse; the output registers add one cycle of latency, so
  // the tick is taken one cycle before the pulse becomes visible.
  assign tick_en = (state_q == S_LOAD) || (state_q == S_RUN);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!tick_en),
    .en_i  (tick_en),
    .tick_o(tick)
  );

  assign run_fire  = tick;
  assign load_fire = tick;
`endif

  assign cmd_ready = (state_q == S_IDLE) && !abort;

  // Next-state and registered-output decode for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    sh_en_d   = 1'b0;
    sh_ctrl_d = sh_ctrl_q;
    sh_din_d  = sh_din_q;
    done_d    = 1'b0;
    steps_d   = steps_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d      = shop_e'(cmd_op);
          count_d   = cmd_count;
          sh_din_d  = cmd_data;
          sh_en_d   = 1'b1;
          sh_ctrl_d = (shop_e'(cmd_op) == OP_CLR) ? OP_CLR : OP_LOAD;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          steps_d = '0;
        end else if (is_load_only(op_q) || (count_q == '0)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          steps_d = count_q;
          if (load_fire) begin
            sh_en_d   = 1'b1;
            sh_ctrl_d = op_q;
            steps_d   = count_q - CNT_W'(1);
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          steps_d = '0;
        end else if (steps_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (run_fire) begin
          sh_en_d   = 1'b1;
          sh_ctrl_d = op_q;
          steps_d   = steps_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CLR;
      count_q   <= '0;
      sh_en_q   <= 1'b0;
      sh_ctrl_q <= OP_CLR;
      sh_din_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      sh_en_q   <= sh_en_d;
      sh_ctrl_q <= sh_ctrl_d;
      sh_din_q  <= sh_din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      steps_q   <= steps_d;
    end
  end

  assign sh_en      = sh_en_q;
  assign sh_ctrl    = sh_ctrl_q;
  assign sh_din     = sh_din_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_q;

endmodule
